// File: rtl/time_bin_to_bcd.sv
// Purpose : converts binary hours/minutes to packed 2-digit BCD fields via double dabble.
// Latency : start sampled at edge k -> done pulses in the cycle after edge k+BIN_W.
// Backpr. : none; start is sampled only in IDLE, and a start seen while busy is dropped.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset (0 = reset)
//   start      in   1   conversion request, sampled only when idle
//   hours      in   5   binary hours 0..31
//   minutes    in   6   binary minutes 0..63
//   busy       out  1   conversion in progress
//   done       out  1   one-cycle pulse: bcd_data/range_err just updated
//   bcd_data   out  16  {hr_tens, hr_units, min_tens, min_units}, held between conversions
//   range_err  out  1   latched inputs exceeded HR_MAX or MIN_MAX
//   pm         out  1   PM indicator (12-hour build only, else constant 0)
//
// Build option: define TWELVE_HR_EN for 12-hour display mode (hours remapped at load,
// pm latched with the result). Without it the block is a plain 24-hour converter.

module time_bin_to_bcd #(
  parameter int BIN_W   = 6,
  parameter int HR_MAX  = 23,
  parameter int MIN_MAX = 59
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  hours,
  input  logic [5:0]  minutes,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_data,
  output logic        range_err,
  output logic        pm
);

  // Shift register layout per field: {tens[3:0], units[3:0], bin[BIN_W-1:0]}
  localparam int SR_W  = 8 + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [4:0] HR_MAX_L  = 5'(HR_MAX);
  localparam logic [5:0] MIN_MAX_L = 6'(MIN_MAX);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [SR_W-1:0]   r_hr_sr;
  logic [SR_W-1:0]   r_min_sr;
  logic [SR_W-1:0]   w_hr_sr_nxt;
  logic [SR_W-1:0]   w_min_sr_nxt;
  logic [SR_W-1:0]   w_hr_step;
  logic [SR_W-1:0]   w_min_step;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              r_err_pend;
  logic              w_err_pend_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_range_err;
  logic              w_range_err_nxt;
  logic [15:0]       r_bcd_data;
  logic [15:0]       w_bcd_data_nxt;

  logic [BIN_W-1:0]  w_hr_load;
  logic              w_in_range_err;

`ifdef TWELVE_HR_EN
  logic              r_pm_pend;
  logic              w_pm_pend_nxt;
  logic              r_pm;
  logic              w_pm_nxt;
`endif

  // One double-dabble iteration: correct each BCD nibble that would overflow
  // past 9 when doubled, then shift the whole {bcd, bin} vector left by one.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    if (t[BIN_W +: 4] >= 4'd5)
      t[BIN_W +: 4] = t[BIN_W +: 4] + 4'd3;
    if (t[BIN_W+4 +: 4] >= 4'd5)
      t[BIN_W+4 +: 4] = t[BIN_W+4 +: 4] + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction

  assign w_hr_step  = dabble_step(r_hr_sr);
  assign w_min_step = dabble_step(r_min_sr);

  // Range judgement always uses the raw 24-hour inputs, even in 12-hour mode.
  assign w_in_range_err = (hours > HR_MAX_L) || (minutes > MIN_MAX_L);

`ifdef TWELVE_HR_EN
  // 12-hour display remap: midnight shows as 12, afternoon hours fold down.
  // Out-of-range hours (24..31) are left as-is so they still convert visibly.
  always_comb begin
    w_hr_load = BIN_W'(hours);
    if (hours == 5'd0)
      w_hr_load = BIN_W'(12);
    else if ((hours >= 5'd13) && (hours <= 5'd23))
      w_hr_load = BIN_W'(hours - 5'd12);
  end
`else
  assign w_hr_load = BIN_W'(hours);
`endif

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt     = r_state;
    w_hr_sr_nxt     = r_hr_sr;
    w_min_sr_nxt    = r_min_sr;
    w_cnt_nxt       = r_cnt;
    w_err_pend_nxt  = r_err_pend;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_range_err_nxt = r_range_err;
    w_bcd_data_nxt  = r_bcd_data;
`ifdef TWELVE_HR_EN
    w_pm_pend_nxt   = r_pm_pend;
    w_pm_nxt        = r_pm;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Load: binary operand in the low bits, BCD scratch cleared.
          w_hr_sr_nxt    = {8'h00, w_hr_load};
          w_min_sr_nxt   = {8'h00, BIN_W'(minutes)};
          w_cnt_nxt      = CNT_W'(BIN_W);
          w_err_pend_nxt = w_in_range_err;
`ifdef TWELVE_HR_EN
          w_pm_pend_nxt  = (hours >= 5'd12);
`endif
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_hr_sr_nxt  = w_hr_step;
        w_min_sr_nxt = w_min_step;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        // cnt == 1 means this edge performs the final shift, so the result is
        // taken straight from the step logic rather than a cycle later.
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_data_nxt  = {w_hr_step[SR_W-1 -: 8], w_min_step[SR_W-1 -: 8]};
          w_range_err_nxt = r_err_pend;
`ifdef TWELVE_HR_EN
          w_pm_nxt        = r_pm_pend;
`endif
          w_done_nxt      = 1'b1;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hr_sr     <= '0;
      r_min_sr    <= '0;
      r_cnt       <= '0;
      r_err_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
      r_bcd_data  <= 16'h0000;
`ifdef TWELVE_HR_EN
      r_pm_pend   <= 1'b0;
      r_pm        <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_hr_sr     <= w_hr_sr_nxt;
      r_min_sr    <= w_min_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_pend  <= w_err_pend_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_range_err <= w_range_err_nxt;
      r_bcd_data  <= w_bcd_data_nxt;
`ifdef TWELVE_HR_EN
      r_pm_pend   <= w_pm_pend_nxt;
      r_pm        <= w_pm_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bcd_data  = r_bcd_data;
  assign range_err = r_range_err;
`ifdef TWELVE_HR_EN
  assign pm        = r_pm;
`else
  assign pm        = 1'b0;
`endif

endmodule

// File: tb/tb_time_bin_to_bcd.sv
module tb_time_bin_to_bcd;

  localparam int BIN_W = 6;

`ifdef TWELVE_HR_EN
  localparam logic [15:0] EXP_1345 = 16'h0145;
  localparam logic [15:0] EXP_0000 = 16'h1200;
  localparam logic [15:0] EXP_2359 = 16'h1159;
  localparam logic        PM_13    = 1'b1;
  localparam logic        PM_24    = 1'b1;
`else
  localparam logic [15:0] EXP_1345 = 16'h1345;
  localparam logic [15:0] EXP_0000 = 16'h0000;
  localparam logic [15:0] EXP_2359 = 16'h2359;
  localparam logic        PM_13    = 1'b0;
  localparam logic        PM_24    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  hours = 5'd0;
  logic [5:0]  minutes = 6'd0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_data;
  logic        range_err;
  logic        pm;

  time_bin_to_bcd dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hours     (hours),
    .minutes   (minutes),
    .busy      (busy),
    .done      (done),
    .bcd_data  (bcd_data),
    .range_err (range_err),
    .pm        (pm)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion straight from decimal digit arithmetic.
  function automatic logic [15:0] ref_bcd(input int h, input int m);
    int hd;
    hd = h;
`ifdef TWELVE_HR_EN
    if (h == 0) hd = 12;
    else if (h >= 13 && h <= 23) hd = h - 12;
`endif
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  // Transaction-level model: an accepted request produces its result
  // BIN_W edges later; requests while a conversion is pending are dropped.
  int          m_rem  = 0;
  int          m_h    = 0;
  int          m_m    = 0;
  logic [15:0] m_bcd  = 16'h0000;
  logic        m_err  = 1'b0;
  logic        m_pm   = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem  = 0;
      m_bcd  = 16'h0000;
      m_err  = 1'b0;
      m_pm   = 1'b0;
      m_done = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_bcd  = ref_bcd(m_h, m_m);
          m_err  = (m_h > 23) || (m_m > 59);
`ifdef TWELVE_HR_EN
          m_pm   = (m_h >= 12);
`else
          m_pm   = 1'b0;
`endif
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        m_h    = int'(hours);
        m_m    = int'(minutes);
        m_rem  = BIN_W;
        m_busy = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc busy",      16'(busy),      16'(m_busy));
    chk("cyc done",      16'(done),      16'(m_done));
    chk("cyc bcd_data",  bcd_data,       m_bcd);
    chk("cyc range_err", 16'(range_err), 16'(m_err));
    chk("cyc pm",        16'(pm),        16'(m_pm));
  end

  // Single start pulse, then wait (bounded) for done and check its latency.
  task automatic convert(input int h, input int m);
    int cyc;
    @(negedge clk);
    hours   = 5'(h);
    minutes = 6'(m);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 16'(cyc), 16'(BIN_W));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy || done) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("idle timeout", 16'(c < 20), 16'(1));
  endtask

  initial begin
    int ndone;
    int last;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy",      16'(busy),      16'(0));
    chk("rst done",      16'(done),      16'(0));
    chk("rst bcd_data",  bcd_data,       16'h0000);
    chk("rst range_err", 16'(range_err), 16'(0));
    chk("rst pm",        16'(pm),        16'(0));
    #2 reset = 1'b1;

    // Basic conversion
    convert(13, 45);
    chk("basic bcd", bcd_data, EXP_1345);
    chk("basic err", 16'(range_err), 16'(0));
    chk("basic pm",  16'(pm), 16'(PM_13));

    // Boundaries
    convert(0, 0);
    chk("zero bcd", bcd_data, EXP_0000);
    chk("zero pm",  16'(pm), 16'(0));
    convert(23, 59);
    chk("max legal bcd", bcd_data, EXP_2359);
    chk("max legal err", 16'(range_err), 16'(0));
    convert(12, 0);
    chk("noon bcd", bcd_data, 16'h1200);
`ifdef TWELVE_HR_EN
    chk("noon pm", 16'(pm), 16'(1));
`endif

    // Range error, then recovery
    convert(24, 63);
    chk("range bcd", bcd_data, 16'h2463);
    chk("range err", 16'(range_err), 16'(1));
    chk("range pm",  16'(pm), 16'(PM_24));
    convert(5, 7);
    chk("recover bcd", bcd_data, 16'h0507);
    chk("recover err", 16'(range_err), 16'(0));
    convert(10, 60);
    chk("min60 bcd", bcd_data, 16'h1060);
    chk("min60 err", 16'(range_err), 16'(1));

    // Re-pulse while busy and change inputs mid-conversion
    @(negedge clk);
    hours = 5'd7; minutes = 6'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hours = 5'd21; minutes = 6'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hours = 5'd3; minutes = 6'd3;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("busy start single done", 16'(ndone), 16'(1));
    chk("busy start bcd", bcd_data, 16'h0730);

    // Start held high: one conversion every BIN_W+1 cycles
    @(negedge clk);
    hours = 5'd9; minutes = 6'd41; start = 1'b1;
    ndone = 0;
    last  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) chk("held gap", 16'(i - last), 16'(BIN_W + 1));
        last = i;
        ndone++;
      end
    end
    start = 1'b0;
    chk("held count", 16'(ndone), 16'(5));
    chk("held bcd", bcd_data, 16'h0941);
    wait_idle();

    // Reset mid-conversion
    @(negedge clk);
    hours = 5'd17; minutes = 6'd22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 16'(busy), 16'(0));
    chk("abort done", 16'(done), 16'(0));
    chk("abort bcd",  bcd_data, 16'h0000);
    @(negedge clk);
    #2 reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", 16'(ndone), 16'(0));

    // Full sweep of every representable input pair
    for (int h = 0; h < 32; h++) begin
      for (int m = 0; m < 64; m++) begin
        convert(h, m);
        chk("sweep bcd", bcd_data, ref_bcd(h, m));
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
